// File: rtl/status_unit_pkg.sv
// Shared definitions for the status unit: flag bit positions, condition codes,
// pending-update states and the saturating update-counter helper.
package status_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pend_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/status_unit_nzcv_reg.sv
// Four-bit NZCV flag register with load enable and synchronous reset.
module nzcv_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] sr_r;

  // Flag storage: reset clears, load captures, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r <= 4'b0000;
    end else if (load) begin
      sr_r <= d;
    end else begin
      sr_r <= sr_r;
    end
  end

  assign q = sr_r;

endmodule

// File: rtl/status_unit.sv
// Condition-flag status unit: committed NZCV with same-cycle bypass, sticky
// overflow, pending-update tracking for the condition stage, and update count.
module status_unit
  import status_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic              exe_s,
  input  logic [3:0]        alu_nzcv,
  input  logic              freeze,
  input  logic              flush,
  input  logic [3:0]        id_cond,
  input  logic              q_clr,
  output logic              N,
  output logic              Z,
  output logic              C,
  output logic              V,
  output logic              Q,
  output logic              flag_hazard,
  output logic [CNT_W-1:0]  upd_count
);

  logic              commit_s;
  logic [3:0]        sr_s;
  logic [3:0]        flags_s;
  pend_state_e       state_r;
  pend_state_e       state_next_s;
  logic              q_r;
  logic              hazard_r;
  logic [CNT_W-1:0]  cnt_r;

  assign commit_s = exe_valid & exe_s & ~flush & ~freeze;

  nzcv_reg u_nzcv_reg (
    .clk  (clk),
    .rst  (rst),
    .load (commit_s),
    .d    (alu_nzcv),
    .q    (sr_s)
  );

  // Bypass the in-flight update to the condition stage; reset shows the register.
  always_comb begin
    flags_s = sr_s;
    if (commit_s && !rst) begin
      flags_s = alu_nzcv;
    end else begin
      flags_s = sr_s;
    end
  end

  assign N = flags_s[FLAG_N];
  assign Z = flags_s[FLAG_Z];
  assign C = flags_s[FLAG_C];
  assign V = flags_s[FLAG_V];

  // Pending-state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next pending state; a back-to-back commit keeps the update in flight.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (commit_s) state_next_s = PEND;
        else          state_next_s = IDLE;
      end
      PEND: begin
        if (freeze)        state_next_s = PEND;
        else if (commit_s) state_next_s = PEND;
        else               state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Sticky overflow: a V=1 commit wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 1'b0;
    end else if (commit_s && alu_nzcv[FLAG_V]) begin
      q_r <= 1'b1;
    end else if (q_clr) begin
      q_r <= 1'b0;
    end else begin
      q_r <= q_r;
    end
  end

  // Registered hazard for a conditional ID instruction stalled behind an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_r <= 1'b0;
    end else begin
      hazard_r <= (state_r == PEND) & freeze & (id_cond != COND_AL);
    end
  end

  // Saturating count of committed flag updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (commit_s) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign Q           = q_r;
  assign flag_hazard = hazard_r;
  assign upd_count   = cnt_r;

endmodule

// File: tb/tb_status_unit.sv
// Directed self-checking bench for status_unit with hand-computed expectations.
module tb_status_unit;

  logic        clk;
  logic        rst;
  logic        exe_valid;
  logic        exe_s;
  logic [3:0]  alu_nzcv;
  logic        freeze;
  logic        flush;
  logic [3:0]  id_cond;
  logic        q_clr;
  logic        N, Z, C, V, Q;
  logic        flag_hazard;
  logic [15:0] upd_count;

  int n_assert = 0;
  int n_fail   = 0;

  status_unit dut (
    .clk         (clk),
    .rst         (rst),
    .exe_valid   (exe_valid),
    .exe_s       (exe_s),
    .alu_nzcv    (alu_nzcv),
    .freeze      (freeze),
    .flush       (flush),
    .id_cond     (id_cond),
    .q_clr       (q_clr),
    .N           (N),
    .Z           (Z),
    .C           (C),
    .V           (V),
    .Q           (Q),
    .flag_hazard (flag_hazard),
    .upd_count   (upd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_commit(input logic [3:0] f);
    exe_valid = 1'b1;
    exe_s     = 1'b1;
    alu_nzcv  = f;
  endtask

  task automatic idle_in();
    exe_valid = 1'b0;
    exe_s     = 1'b0;
    alu_nzcv  = 4'b0000;
    freeze    = 1'b0;
    flush     = 1'b0;
    q_clr     = 1'b0;
    id_cond   = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("reset_flags", {12'h000, N, Z, C, V}, 16'h0000);
    check("reset_q", {15'h0000, Q}, 16'h0000);
    check("reset_cnt", upd_count, 16'h0000);
    check("reset_hazard", {15'h0000, flag_hazard}, 16'h0000);

    // Commit with bypass
    set_commit(4'b0110);
    settle();
    check("bypass_0110", {12'h000, N, Z, C, V}, 16'h0006);
    tick();
    idle_in();
    settle();
    check("sr_0110", {12'h000, N, Z, C, V}, 16'h0006);
    check("cnt_after_first", upd_count, 16'h0001);

    // Flush blocks commit
    set_commit(4'b1111);
    flush = 1'b1;
    settle();
    check("flush_no_bypass", {12'h000, N, Z, C, V}, 16'h0006);
    tick();
    flush  = 1'b0;
    freeze = 1'b1;
    settle();
    check("flush_sr_hold", {12'h000, N, Z, C, V}, 16'h0006);
    check("flush_cnt_hold", upd_count, 16'h0001);
    tick();
    idle_in();
    settle();
    check("freeze_sr_hold", {12'h000, N, Z, C, V}, 16'h0006);
    check("freeze_cnt_hold", upd_count, 16'h0001);

    // Hazard with conditional id_cond
    set_commit(4'b0000);
    tick();
    idle_in();
    freeze  = 1'b1;
    id_cond = 4'b0000;
    tick();
    check("hazard_cond0000", {15'h0000, flag_hazard}, 16'h0001);
    idle_in();
    tick();
    check("hazard_cleared", {15'h0000, flag_hazard}, 16'h0000);

    // Same sequence with AL never hazards
    set_commit(4'b0000);
    tick();
    idle_in();
    freeze  = 1'b1;
    id_cond = 4'b1110;
    tick();
    check("hazard_al", {15'h0000, flag_hazard}, 16'h0000);
    idle_in();
    tick();

    // Reserved cond hazards; flush in PEND keeps the pending state
    set_commit(4'b0000);
    tick();
    idle_in();
    freeze  = 1'b1;
    flush   = 1'b1;
    id_cond = 4'b1111;
    tick();
    check("hazard_cond1111_flush", {15'h0000, flag_hazard}, 16'h0001);
    idle_in();
    tick();
    check("cnt_after_hazards", upd_count, 16'h0004);

    // Sticky Q
    set_commit(4'b0001);
    tick();
    check("q_set", {15'h0000, Q}, 16'h0001);
    set_commit(4'b1000);
    tick();
    check("q_stays", {15'h0000, Q}, 16'h0001);
    idle_in();
    settle();
    check("sr_1000", {12'h000, N, Z, C, V}, 16'h0008);
    set_commit(4'b0001);
    q_clr = 1'b1;
    tick();
    check("q_set_wins", {15'h0000, Q}, 16'h0001);
    idle_in();
    q_clr = 1'b1;
    tick();
    check("q_clr_alone", {15'h0000, Q}, 16'h0000);
    idle_in();
    settle();
    check("cnt_after_q", upd_count, 16'h0007);

    // Reset overrides commit and q_clr; bypass off during reset
    rst = 1'b1;
    set_commit(4'b1111);
    q_clr = 1'b1;
    settle();
    check("rst_no_bypass", {12'h000, N, Z, C, V}, 16'h0001);
    tick();
    check("rst_sr", {12'h000, N, Z, C, V}, 16'h0000);
    check("rst_cnt", upd_count, 16'h0000);
    check("rst_q", {15'h0000, Q}, 16'h0000);
    rst = 1'b0;
    idle_in();

    // Reset mid-PEND returns to IDLE
    set_commit(4'b0010);
    tick();
    idle_in();
    freeze = 1'b1;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_midpend_hazard", {15'h0000, flag_hazard}, 16'h0000);
    check("rst_midpend_sr", {12'h000, N, Z, C, V}, 16'h0000);
    idle_in();

    // Freeze holds the instruction until the first unfrozen cycle
    set_commit(4'b0100);
    freeze = 1'b1;
    settle();
    check("freeze_no_bypass", {12'h000, N, Z, C, V}, 16'h0000);
    tick();
    freeze = 1'b0;
    settle();
    check("unfreeze_bypass", {12'h000, N, Z, C, V}, 16'h0004);
    tick();
    idle_in();
    settle();
    check("unfreeze_sr", {12'h000, N, Z, C, V}, 16'h0004);
    check("unfreeze_cnt", upd_count, 16'h0001);

    // Saturation: bring counter to FFFE, then three more commits
    set_commit(4'b0000);
    for (int i = 0; i < 65533; i++) begin
      tick();
    end
    idle_in();
    settle();
    check("cnt_preload", upd_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      set_commit(4'b0000);
      tick();
      idle_in();
      settle();
      check("cnt_saturate", upd_count, 16'hFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
